// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and uart_tx side signals of the arbiter
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [15:0]       cfg_baudrate;
  logic [1:0]        cfg_parity_sel;
  logic              cfg_stop_sel;
  logic              tx_done;
  logic              tx_send_en;
  logic [7:0]        tx_tdata;
  logic [15:0]       tx_baudrate;
  logic [1:0]        tx_parity_sel;
  logic              tx_stop_sel;

  modport master (
    output req_valid, req_data, cfg_baudrate, cfg_parity_sel, cfg_stop_sel, tx_done,
    input  req_ready, tx_send_en, tx_tdata, tx_baudrate, tx_parity_sel, tx_stop_sel
  );

  modport slave (
    input  req_valid, req_data, cfg_baudrate, cfg_parity_sel, cfg_stop_sel, tx_done,
    output req_ready, tx_send_en, tx_tdata, tx_baudrate, tx_parity_sel, tx_stop_sel
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sequencer sharing one uart_tx among NREQ byte sources
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int ACK_TIMEOUT = 4,
  localparam int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               mclk,
  input  logic               n_reset,
  uart_tx_arbiter_if.slave   bus,
  output logic [IDW-1:0]     o_grant_id,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_err,
  input  logic               i_err_clr
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_rr;
  logic [CW-1:0]   r_ack_cnt;
  logic [7:0]      r_tdata;
  logic [15:0]     r_baudrate;
  logic [1:0]      r_parity_sel;
  logic            r_stop_sel;
  logic [IDW-1:0]  r_grant_id;
  logic            r_err;

  logic            w_found;
  logic [IDW-1:0]  w_winner;
  logic [IDW-1:0]  w_idx;
  logic [NREQ-1:0] w_ready;
  logic            w_accept;
  logic            w_send_en;
  logic            w_frame_done;
  logic            w_timeout;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((int'(r_rr) + k) % NREQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_ff @(posedge mclk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ready      = '0;
    w_accept     = 1'b0;
    w_send_en    = 1'b0;
    w_frame_done = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.tx_done && w_found) begin
          w_ready     = NREQ'(1) << w_winner;
          w_accept    = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        w_send_en   = 1'b1;
        w_state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!bus.tx_done) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_ack_cnt == CW'(ACK_TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.tx_done) begin
          w_frame_done = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Byte and frame config are captured only at accept, so the uart sees a stable frame.
  always_ff @(posedge mclk or negedge n_reset) begin
    if (!n_reset) begin
      r_rr         <= IDW'(NREQ - 1);
      r_tdata      <= '0;
      r_baudrate   <= '0;
      r_parity_sel <= '0;
      r_stop_sel   <= 1'b0;
      r_grant_id   <= '0;
    end else if (w_accept) begin
      r_rr         <= w_winner;
      r_tdata      <= bus.req_data[{w_winner, 3'b000} +: 8];
      r_baudrate   <= bus.cfg_baudrate;
      r_parity_sel <= bus.cfg_parity_sel;
      r_stop_sel   <= bus.cfg_stop_sel;
      r_grant_id   <= w_winner;
    end
  end

  always_ff @(posedge mclk or negedge n_reset) begin
    if (!n_reset) begin
      r_ack_cnt <= '0;
    end else if (r_state == ST_SEND) begin
      r_ack_cnt <= '0;
    end else if (r_state == ST_WAIT_ACK && bus.tx_done && !w_timeout) begin
      r_ack_cnt <= r_ack_cnt + 1'b1;
    end
  end

  always_ff @(posedge mclk or negedge n_reset) begin
    if (!n_reset) begin
      r_err <= 1'b0;
    end else if (i_err_clr) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign bus.req_ready     = w_ready;
  assign bus.tx_send_en    = w_send_en;
  assign bus.tx_tdata      = r_tdata;
  assign bus.tx_baudrate   = r_baudrate;
  assign bus.tx_parity_sel = r_parity_sel;
  assign bus.tx_stop_sel   = r_stop_sel;
  assign o_grant_id        = r_grant_id;
  assign o_busy            = (r_state != ST_IDLE);
  assign o_frame_done      = w_frame_done;
  assign o_err             = r_err;

endmodule
